// File: rtl/ram_share_arbiter.sv
// ram_share_arbiter: shares one 1-cycle-latency single-port SRAM between the instruction and data ports
// Ports: Clk/Rst; instr_* and data_* req/gnt/rvalid requester ports; mem_* SRAM master port.
// Define ARB_ROUND_ROBIN_EN for alternating priority; the default is data-over-instr with a MaxWait starvation guard.
module ram_share_arbiter #(
  parameter logic [31:0] MemStart = 32'h0000_0000,
  parameter int          MemSize  = 65536,
  parameter int          MaxWait  = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        instr_req,
  output logic        instr_gnt,
  output logic        instr_rvalid,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_rdata,
  output logic        instr_err,
  input  logic        data_req,
  output logic        data_gnt,
  output logic        data_rvalid,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {OWN_NONE, OWN_INSTR, OWN_DATA} owner_e;
  localparam logic [31:0] Mask = ~(32'(MemSize) - 32'd1);
  logic   instr_win, data_win, instr_in, data_in, instr_sel, data_sel;
  owner_e resp_owner_q, resp_owner_d;
  logic   resp_err_q, resp_err_d;
`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_winner_q, last_winner_d;
  always_comb begin
    data_win      = !Rst && data_req && (!instr_req || last_winner_q == OWN_INSTR);
    instr_win     = !Rst && instr_req && !data_win;
    last_winner_d = data_win ? OWN_DATA : instr_win ? OWN_INSTR : last_winner_q;
  end
  always_ff @(posedge Clk) last_winner_q <= Rst ? OWN_INSTR : last_winner_d;
`else
  logic [3:0] wait_cnt_q, wait_cnt_d;
  // instr is the fixed loser; once it has lost MaxWait cycles in a row it takes the slot
  always_comb begin
    instr_win  = !Rst && instr_req && (!data_req || wait_cnt_q == 4'(MaxWait));
    data_win   = !Rst && data_req && !instr_win;
    wait_cnt_d = (instr_req && !instr_win) ? wait_cnt_q + 4'd1 : 4'd0;
  end
  always_ff @(posedge Clk) wait_cnt_q <= Rst ? 4'd0 : wait_cnt_d;
`endif
  always_comb begin
    instr_in     = (instr_addr & Mask) == MemStart;
    data_in      = (data_addr & Mask) == MemStart;
    instr_sel    = instr_win && instr_in;
    data_sel     = data_win && data_in;
    instr_gnt    = instr_win;
    data_gnt     = data_win;
    mem_req      = instr_sel || data_sel;
    mem_we       = data_sel && data_we;
    mem_be       = data_sel ? data_be : instr_sel ? 4'hF : 4'h0;
    mem_addr     = data_sel ? data_addr : instr_sel ? instr_addr : 32'h0;
    mem_wdata    = data_sel ? data_wdata : 32'h0;
    resp_owner_d = data_win ? OWN_DATA : instr_win ? OWN_INSTR : OWN_NONE;
    resp_err_d   = data_win ? !data_in : instr_win && !instr_in;
    // gating on Rst drops a response still in flight when reset arrives
    instr_rvalid = !Rst && resp_owner_q == OWN_INSTR;
    data_rvalid  = !Rst && resp_owner_q == OWN_DATA;
    instr_err    = instr_rvalid && resp_err_q;
    data_err     = data_rvalid && resp_err_q;
    instr_rdata  = (instr_rvalid && !resp_err_q) ? mem_rdata : 32'h0;
    data_rdata   = (data_rvalid && !resp_err_q) ? mem_rdata : 32'h0;
  end
  always_ff @(posedge Clk) begin
    resp_owner_q <= Rst ? OWN_NONE : resp_owner_d;
    resp_err_q   <= Rst ? 1'b0 : resp_err_d;
  end
endmodule

// File: tb/tb_ram_share_arbiter.sv
// tb_ram_share_arbiter: directed self-checking bench for ram_share_arbiter
module tb_ram_share_arbiter;
  logic        Clk = 1'b0, Rst = 1'b1, init = 1'b1;
  logic        instr_req = 1'b0, instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_addr = '0, instr_rdata;
  logic        data_req = 1'b0, data_gnt, data_rvalid, data_we = 1'b0, data_err;
  logic [3:0]  data_be = '0;
  logic [31:0] data_addr = '0, data_wdata = '0, data_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [31:0] mem [0:16383];
  int          tests = 0, fails = 0;

  ram_share_arbiter dut (
    .Clk(Clk), .Rst(Rst),
    .instr_req(instr_req), .instr_gnt(instr_gnt), .instr_rvalid(instr_rvalid),
    .instr_addr(instr_addr), .instr_rdata(instr_rdata), .instr_err(instr_err),
    .data_req(data_req), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_err(data_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (init) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 32'h0;
      mem[14'h0400] <= 32'hDEADBEEF;
      mem[14'h0C00] <= 32'h11111111;
      mem[14'h0C40] <= 32'h22222222;
    end else if (mem_req) begin
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[15:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= mem[mem_addr[15:2]];
    end
  end

  task automatic cyc;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle;
    instr_req = 1'b0; data_req = 1'b0; data_we = 1'b0; data_be = 4'h0;
    instr_addr = '0; data_addr = '0; data_wdata = '0;
  endtask

  function automatic logic [139:0] all_out();
    return {instr_gnt, instr_rvalid, instr_rdata, instr_err, data_gnt, data_rvalid,
            data_rdata, data_err, mem_req, mem_we, mem_be, mem_addr, mem_wdata};
  endfunction

  task automatic test_reset;
    Rst = 1'b1;
    instr_req = 1'b1; instr_addr = 32'h1000;
    data_req = 1'b1; data_addr = 32'h1000; data_be = 4'hF;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 0) init = 1'b0;
      tests++;
      if (all_out() !== '0) begin
        fails++; $display("FAIL reset_outputs cycle %0d: got %h want 0", i, all_out());
      end
    end
    Rst = 1'b0;
    #1;
    tests++;
    if ({data_gnt, instr_gnt, mem_req} !== 3'b101) begin
      fails++; $display("FAIL reset_first_gnt: got d/i/mreq=%b want 101", {data_gnt, instr_gnt, mem_req});
    end
    cyc();
    tests++;
    if ({data_rvalid, instr_rvalid, data_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      fails++; $display("FAIL reset_first_rvalid: got %b %b %h want 1 0 deadbeef", data_rvalid, instr_rvalid, data_rdata);
    end
    idle();
    cyc();
  endtask

  task automatic test_single_read;
    instr_req = 1'b1; instr_addr = 32'h1000;
    #1;
    tests++;
    if ({instr_gnt, data_gnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {4'b1010, 4'hF, 32'h1000, 32'h0}) begin
      fails++; $display("FAIL single_read_gnt: got g=%b mreq=%b we=%b be=%h a=%h wd=%h want 1 1 0 f 1000 0",
                        instr_gnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
    end
    cyc();
    tests++;
    if ({instr_rvalid, instr_err, data_rvalid, instr_rdata} !== {3'b100, 32'hDEADBEEF}) begin
      fails++; $display("FAIL single_read_resp: got v=%b e=%b dv=%b d=%h want 1 0 0 deadbeef",
                        instr_rvalid, instr_err, data_rvalid, instr_rdata);
    end
    idle();
    cyc();
    tests++;
    if ({instr_rvalid, data_rvalid, instr_rdata} !== 34'h0) begin
      fails++; $display("FAIL single_read_idle: got v=%b dv=%b d=%h want 0 0 0", instr_rvalid, data_rvalid, instr_rdata);
    end
  endtask

  task automatic test_byte_write;
    data_req = 1'b1; data_we = 1'b1; data_be = 4'b0010; data_addr = 32'h2004; data_wdata = 32'h0000AB00;
    #1;
    tests++;
    if ({data_gnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {3'b111, 4'b0010, 32'h2004, 32'h0000AB00}) begin
      fails++; $display("FAIL write_gnt: got g=%b mreq=%b we=%b be=%b a=%h wd=%h want 1 1 1 0010 2004 0000ab00",
                        data_gnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
    end
    cyc();
    tests++;
    if ({data_rvalid, data_err, instr_rvalid} !== 3'b100) begin
      fails++; $display("FAIL write_resp: got v=%b e=%b iv=%b want 1 0 0", data_rvalid, data_err, instr_rvalid);
    end
    data_we = 1'b0; data_be = 4'hF; data_wdata = 32'h0;
    #1;
    tests++;
    if ({data_gnt, mem_req, mem_we} !== 3'b110) begin
      fails++; $display("FAIL readback_gnt: got g=%b mreq=%b we=%b want 1 1 0", data_gnt, mem_req, mem_we);
    end
    cyc();
    tests++;
    if ({data_rvalid, data_err, data_rdata} !== {2'b10, 32'h0000AB00}) begin
      fails++; $display("FAIL readback_resp: got v=%b e=%b d=%h want 1 0 0000ab00", data_rvalid, data_err, data_rdata);
    end
    idle();
    cyc();
    tests++;
    if (data_rvalid !== 1'b0) begin
      fails++; $display("FAIL readback_idle: got v=%b want 0", data_rvalid);
    end
  endtask

  task automatic check_contention(input string name, input logic exp_instr, input int i);
    tests++;
    if ({instr_gnt, data_gnt} !== {exp_instr, !exp_instr}) begin
      fails++; $display("FAIL %s_gnt cycle %0d: got i/d=%b%b want %b%b", name, i, instr_gnt, data_gnt, exp_instr, !exp_instr);
    end
    cyc();
    tests++;
    if ({instr_rvalid, data_rvalid, instr_rdata, data_rdata} !==
        {exp_instr, !exp_instr, exp_instr ? 32'h11111111 : 32'h0, exp_instr ? 32'h0 : 32'h22222222}) begin
      fails++; $display("FAIL %s_resp cycle %0d: got iv=%b dv=%b id=%h dd=%h", name, i, instr_rvalid, data_rvalid, instr_rdata, data_rdata);
    end
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  task automatic test_round_robin;
    Rst = 1'b1;
    cyc();
    cyc();
    instr_req = 1'b1; instr_addr = 32'h3000;
    data_req = 1'b1; data_addr = 32'h3100; data_be = 4'hF;
    Rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check_contention("round_robin", i % 2 == 1, i);
    end
    idle();
    cyc();
  endtask
`else
  task automatic test_starvation;
    instr_req = 1'b1; instr_addr = 32'h3000;
    data_req = 1'b1; data_addr = 32'h3100; data_be = 4'hF;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_contention("starve", i == 4 || i == 9, i);
    end
    idle();
    cyc();
  endtask
`endif

  task automatic test_oow_reset;
    data_req = 1'b1; data_addr = 32'h0001_0000; data_be = 4'hF;
    #1;
    tests++;
    if ({data_gnt, mem_req} !== 2'b10) begin
      fails++; $display("FAIL oow_gnt: got g=%b mreq=%b want 1 0", data_gnt, mem_req);
    end
    cyc();
    tests++;
    if ({data_rvalid, data_err, data_rdata} !== {2'b11, 32'h0}) begin
      fails++; $display("FAIL oow_resp: got v=%b e=%b d=%h want 1 1 0", data_rvalid, data_err, data_rdata);
    end
    data_addr = 32'h1000;
    #1;
    tests++;
    if ({data_gnt, mem_req} !== 2'b11) begin
      fails++; $display("FAIL midop_gnt: got g=%b mreq=%b want 1 1", data_gnt, mem_req);
    end
    cyc();
    Rst = 1'b1;
    idle();
    #1;
    tests++;
    if (all_out() !== '0) begin
      fails++; $display("FAIL midop_reset_outputs: got %h want 0", all_out());
    end
    cyc();
    Rst = 1'b0;
    cyc();
    tests++;
    if (all_out() !== '0) begin
      fails++; $display("FAIL post_reset_outputs: got %h want 0", all_out());
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_byte_write();
`ifdef ARB_ROUND_ROBIN_EN
    test_round_robin();
`else
    test_starvation();
`endif
    test_oow_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
